// File: rtl/md5_msg_packer_if.sv
// rtl/md5_msg_packer_if.sv - byte-stream input and padded-block output handshakes of the MD5 packer
interface md5_msg_packer_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [5:0]   blk_len;
  logic         ovf_err;

  modport master (
    output in_data, in_valid, in_last, in_empty, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_len, ovf_err
  );

  modport slave (
    input  in_data, in_valid, in_last, in_empty, blk_ready,
    output in_ready, blk_data, blk_valid, blk_len, ovf_err
  );
endinterface

// File: rtl/md5_msg_packer.sv
// rtl/md5_msg_packer.sv - collects a short message byte stream into one padded 512-bit MD5 block
module md5_msg_packer #(
  parameter int MAX_BYTES = 55
) (
  input  logic           clk,
  input  logic           rst,
  md5_msg_packer_if.slave bus
);

  if (MAX_BYTES < 1 || MAX_BYTES > 55) begin : g_bad_max_bytes
    $error("md5_msg_packer: MAX_BYTES must be within 1..55");
  end

  localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   count_q;
  logic [511:0] blk_data_q;
  logic [511:0] padded;
  logic [5:0]   blk_len_q;
  logic         ovf_q;
  logic         beat;
  logic         has_byte;
  logic         overflow;
  logic [8:0]   wr_lsb;

  assign beat     = bus.in_valid && bus.in_ready;
  assign has_byte = !(bus.in_last && bus.in_empty);
  assign overflow = has_byte && (count_q == MAX_CNT);
  assign wr_lsb   = 9'd504 - {count_q, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          if (overflow) begin
            state_d = bus.in_last ? COLLECT : DRAIN;
          end else if (bus.in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD:     state_d = HOLD;
      HOLD:    if (bus.blk_ready) state_d = COLLECT;
      DRAIN:   if (beat && bus.in_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Every byte from count upward is rewritten, so nothing from an earlier message survives.
  always_comb begin
    padded = blk_data_q;
    for (int i = 0; i < 56; i++) begin
      if (6'(i) == count_q) begin
        padded[511 - 8*i -: 8] = 8'h80;
      end else if (6'(i) > count_q) begin
        padded[511 - 8*i -: 8] = 8'h00;
      end
    end
    // Bit length is count*8, up to 9 bits: byte 56 holds the low eight, byte 57 holds bit 8.
    padded[63:56] = {count_q[4:0], 3'b000};
    padded[55:48] = {7'b0000000, count_q[5]};
    padded[47:0]  = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      blk_data_q <= '0;
      blk_len_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (beat && has_byte) begin
            if (overflow) begin
              if (bus.in_last) begin
                ovf_q   <= 1'b1;
                count_q <= '0;
              end
            end else begin
              blk_data_q[wr_lsb +: 8] <= bus.in_data;
              count_q                 <= count_q + 6'd1;
            end
          end
        end
        PAD: begin
          blk_data_q <= padded;
          blk_len_q  <= count_q;
        end
        HOLD: begin
          if (bus.blk_ready) count_q <= '0;
        end
        DRAIN: begin
          if (beat && bus.in_last) begin
            ovf_q   <= 1'b1;
            count_q <= '0;
          end
        end
        default: count_q <= '0;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT) || (state_q == DRAIN);
  assign bus.blk_valid = (state_q == HOLD);
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_len   = blk_len_q;
  assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_md5_msg_packer.sv
// tb/tb_md5_msg_packer.sv - scoreboard bench for md5_msg_packer with directed messages
module tb_md5_msg_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  md5_msg_packer_if bus ();

  md5_msg_packer #(.MAX_BYTES(55)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [511:0] data;
    logic [5:0]   len;
  } exp_t;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h1800_0000_0000_0000};
  localparam logic [511:0] BLK_A     = {16'h6180, 432'h0, 64'h0800_0000_0000_0000};
  localparam logic [511:0] BLK_EMPTY = {8'h80, 440'h0, 64'h0};
  localparam logic [511:0] BLK_55    = {{55{8'h41}}, 8'h80, 64'hB801_0000_0000_0000};

  exp_t       exp_q [$];
  exp_t       e;
  logic [7:0] msg [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ovf_total = 0;
  int         first_wait = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Sends msg[0..n-1]; term appends an empty terminator beat; has_last=0 leaves the message open.
  task automatic send(input int n, input bit term, input bit has_last);
    int beats;
    int t;
    beats = n + (term ? 1 : 0);
    for (int i = 0; i < beats; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < n) ? msg[i] : 8'h00;
      bus.in_last  = has_last && (i == beats - 1);
      bus.in_empty = term && (i == n);
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (i == 0) first_wait = t;
      if (t >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: beat %0d not accepted within %0d cycles", i, t);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic fill(input int n, input logic [7:0] b);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(b);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ovf_err) ovf_total++;
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_block: got block len %0d want no block", bus.blk_len);
        end else begin
          e = exp_q.pop_front();
          check("blk_data", bus.blk_data, e.data);
          check("blk_len", 512'(bus.blk_len), 512'(e.len));
        end
      end
    end
  end

  initial begin
    idle();
    bus.blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 512'(bus.in_ready), 512'(1));
    check("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    check("rst_blk_len", 512'(bus.blk_len), 512'(0));
    check("rst_ovf_err", 512'(bus.ovf_err), 512'(0));
    check("rst_blk_data", bus.blk_data, 512'(0));
    rst = 1'b1;
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;

    // "abc" with latency check
    msg = {8'h61, 8'h62, 8'h63};
    exp_q.push_back('{BLK_ABC, 6'd3});
    send(3, 1'b0, 1'b1);
    idle();
    check("abc_pad_not_valid", 512'(bus.blk_valid), 512'(0));
    check("abc_pad_in_ready", 512'(bus.in_ready), 512'(0));
    @(posedge clk); #1;
    check("abc_valid", 512'(bus.blk_valid), 512'(1));
    repeat (3) @(posedge clk);
    #1;

    // empty message
    exp_q.push_back('{BLK_EMPTY, 6'd0});
    send(0, 1'b1, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // 55 bytes with the consumer stalled for 10 cycles
    bus.blk_ready = 1'b0;
    fill(55, 8'h41);
    exp_q.push_back('{BLK_55, 6'd55});
    send(55, 1'b0, 1'b1);
    idle();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 512'(bus.blk_valid), 512'(1));
      check("stall_in_ready", 512'(bus.in_ready), 512'(0));
      check("stall_data", bus.blk_data, BLK_55);
      @(posedge clk); #1;
    end
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", 512'(bus.blk_valid), 512'(0));
    check("stall_release_ready", 512'(bus.in_ready), 512'(1));

    // 56 bytes: overflow on the last beat itself
    fill(56, 8'h42);
    send(56, 1'b0, 1'b1);
    idle();
    check("ovf56_pulse", 512'(bus.ovf_err), 512'(1));
    check("ovf56_no_valid", 512'(bus.blk_valid), 512'(0));
    @(posedge clk); #1;
    check("ovf56_pulse_end", 512'(bus.ovf_err), 512'(0));
    msg = {8'h61};
    exp_q.push_back('{BLK_A, 6'd1});
    send(1, 1'b0, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // 60 bytes: overflow mid-message, remainder drained
    fill(60, 8'h43);
    send(60, 1'b0, 1'b1);
    idle();
    check("ovf60_pulse", 512'(bus.ovf_err), 512'(1));
    @(posedge clk); #1;
    check("ovf60_pulse_end", 512'(bus.ovf_err), 512'(0));
    check("ovf60_no_valid", 512'(bus.blk_valid), 512'(0));
    check("ovf60_in_ready", 512'(bus.in_ready), 512'(1));

    // back-to-back "abc" then "a" with in_valid held high
    exp_q.push_back('{BLK_ABC, 6'd3});
    exp_q.push_back('{BLK_A, 6'd1});
    msg = {8'h61, 8'h62, 8'h63};
    send(3, 1'b0, 1'b1);
    msg = {8'h61};
    send(1, 1'b0, 1'b1);
    check("b2b_in_ready_gap", 512'(first_wait), 512'(2));
    idle();
    repeat (4) @(posedge clk);
    #1;

    // reset after two bytes of a message
    msg = {8'h61, 8'h62, 8'h63};
    send(2, 1'b0, 1'b0);
    idle();
    #2 rst = 1'b0;
    #1;
    check("midrst_in_ready", 512'(bus.in_ready), 512'(1));
    check("midrst_blk_data", bus.blk_data, 512'(0));
    check("midrst_ovf", 512'(bus.ovf_err), 512'(0));
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // reset while a block is held
    bus.blk_ready = 1'b0;
    send(3, 1'b0, 1'b1);
    idle();
    @(posedge clk); #1;
    check("holdrst_pre_valid", 512'(bus.blk_valid), 512'(1));
    #2 rst = 1'b0;
    #1;
    check("holdrst_valid", 512'(bus.blk_valid), 512'(0));
    check("holdrst_in_ready", 512'(bus.in_ready), 512'(1));
    check("holdrst_blk_len", 512'(bus.blk_len), 512'(0));
    check("holdrst_blk_data", bus.blk_data, 512'(0));
    #2 rst = 1'b1;
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;

    exp_q.push_back('{BLK_ABC, 6'd3});
    send(3, 1'b0, 1'b1);
    idle();
    repeat (5) @(posedge clk);
    #1;

    check("queue_drained", 512'(exp_q.size()), 512'(0));
    check("ovf_pulse_count", 512'(ovf_total), 512'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
